// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared definitions for the dynamic branch predictor:
//   BHT_INDEX_BITS  default table index width (table has 2^BHT_INDEX_BITS entries)
//   bht_cnt_e       2-bit saturating counter states; MSB set means "predict taken"
//   pc_plus4        sequential next-PC helper (wraps mod 2^32)
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  localparam int BHT_INDEX_BITS = 6;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// -----------------------------------------------------------------------------
// branch_predictor_sat_counter2
// Combinational next state of a 2-bit saturating branch counter.
//   cnt       current counter state
//   taken     resolved branch outcome
//   cnt_next  counter moved one step toward the outcome, clamped at SNT/ST
// -----------------------------------------------------------------------------
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != BHT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != BHT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped 2-bit counter table with BTB targets. Predicts at IF
// (combinational), learns from branches resolved at EX, and raises a one-cycle
// registered redirect when the carried prediction turns out wrong.
//   clock, reset          rising-edge clock, synchronous active-low reset
//   if_pc                 fetch PC -> pred_taken / pred_target
//   ex_*                  resolved instruction in EX with its carried prediction
//   redirect_valid/_pc    flush request and correct next PC
//   branch_count          resolved branches (saturating)
//   mispredict_count      mispredicted branches (saturating)
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = BHT_INDEX_BITS,
  parameter int TAG_BITS   = 30 - INDEX_BITS,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_branch,
  input  logic                 ex_stall,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Plain register arrays: every entry must clear on a synchronous reset.
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [1:0]          cnt_q    [ENTRIES];
  logic [29:0]         target_q [ENTRIES];

  logic                 redirect_valid_q, redirect_valid_d;
  logic [31:0]          redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;

  // ---------------- IF lookup ----------------
  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_BITS-1:0]   if_tag;
  logic                  if_hit;

  assign if_idx      = if_pc[2 +: INDEX_BITS];
  assign if_tag      = if_pc[2+INDEX_BITS +: TAG_BITS];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && cnt_q[if_idx][1];
  assign pred_target = pred_taken ? {target_q[if_idx], 2'b00} : pc_plus4(if_pc);

  // ---------------- EX resolve ----------------
  logic [INDEX_BITS-1:0] ex_idx;
  logic [TAG_BITS-1:0]   ex_tag;
  logic                  ex_hit;
  logic                  resolve;
  logic                  mispredict;
  logic [1:0]            cnt_upd;

  assign ex_idx = ex_pc[2 +: INDEX_BITS];
  assign ex_tag = ex_pc[2+INDEX_BITS +: TAG_BITS];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // The instruction in EX during a redirect cycle is wrong-path and is dropped.
  assign resolve    = ex_valid && ex_branch && !ex_stall && !redirect_valid_q;
  assign mispredict = resolve && ((ex_taken != ex_pred_taken) ||
                                  (ex_taken && (ex_pred_target != ex_target)));

  branch_predictor_sat_counter2 u_sat_counter2 (
    .cnt      (cnt_q[ex_idx]),
    .taken    (ex_taken),
    .cnt_next (cnt_upd)
  );

  logic        wr_en;
  logic [1:0]  wr_cnt_d;
  logic [29:0] wr_target_d;

  always_comb begin
    wr_en       = 1'b0;
    wr_cnt_d    = cnt_upd;
    wr_target_d = ex_target[31:2];
    if (resolve) begin
      if (ex_hit) begin
        wr_en = 1'b1;
        // A not-taken outcome keeps the previously learned target.
        if (!ex_taken) wr_target_d = target_q[ex_idx];
      end else if (ex_taken) begin
        wr_en    = 1'b1;
        wr_cnt_d = BHT_WT;
      end
    end
  end

  always_comb begin
    redirect_valid_d   = mispredict;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (mispredict) redirect_pc_d = ex_taken ? ex_target : pc_plus4(ex_pc);
    if (resolve && (branch_count_q != {CNT_WIDTH{1'b1}}))
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
    if (mispredict && (mispredict_count_q != {CNT_WIDTH{1'b1}}))
      mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
  end

  // ---------------- State ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= BHT_WNT;
        target_q[i] <= '0;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      cnt_q[ex_idx]    <= wr_cnt_d;
      target_q[ex_idx] <= wr_target_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed scenarios followed by randomized traffic. A behavioural table model
// produces expected predictions, redirects and counts; a monitor compares them.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  localparam int IB   = 6;
  localparam int ENT  = 1 << IB;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [31:0]   if_pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          ex_valid, ex_branch, ex_stall;
  logic [31:0]   ex_pc;
  logic          ex_pred_taken;
  logic [31:0]   ex_pred_target;
  logic          ex_taken;
  logic [31:0]   ex_target;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  branch_predictor #(.INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_stall         (ex_stall),
    .ex_pc            (ex_pc),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        chk;
    logic        tk;
    logic [31:0] tg;
    logic [31:0] pc;
  } pred_t;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    int          bc;
    int          mc;
  } out_t;

  pred_t       pred_q[$];
  out_t        out_q[$];
  logic [31:0] rd_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_init = 0;
  bit          m_valid [ENT];
  logic [31:0] m_tag   [ENT];
  int          m_cnt   [ENT];
  logic [31:0] m_tgt   [ENT];
  bit          m_rv;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;

  function automatic int m_index(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc >> (2 + IB);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i = m_index(pc);
    return m_valid[i] && (m_tag[i] == m_tagof(pc));
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i = m_index(pc);
    tk = m_hit(pc) && (m_cnt[i] >= 2);
    tg = tk ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_cnt[i] = 1; m_tgt[i] = '0;
    end
    m_rv = 0; m_rpc = '0; m_bc = 0; m_mc = 0; m_init = 1;
  endtask

  // One clock cycle of stimulus; the model advances past the following edge.
  task automatic cyc(input logic rn, input logic v, input logic br, input logic st,
                     input logic [31:0] epc, input logic tk, input logic [31:0] etg,
                     input logic [31:0] ipc, input bit use_pred);
    logic        ptk;
    logic [31:0] ptg;
    pred_t       p;
    out_t        o;
    bit          res, mis, hit;
    int          i;
    @(negedge clock);
    if (use_pred) m_lookup(epc, ptk, ptg);
    else begin
      ptk = 1'($urandom_range(0, 1));
      ptg = rnd_tgt();
    end
    reset = rn; if_pc = ipc; ex_valid = v; ex_branch = br; ex_stall = st;
    ex_pc = epc; ex_pred_taken = ptk; ex_pred_target = ptg; ex_taken = tk; ex_target = etg;

    p.chk = m_init; p.pc = ipc;
    m_lookup(ipc, p.tk, p.tg);
    pred_q.push_back(p);

    if (!rn) m_reset();
    else begin
      res = v && br && !st && !m_rv;
      mis = res && ((tk != ptk) || (tk && (ptg != etg)));
      i   = m_index(epc);
      hit = m_hit(epc);
      if (res && hit) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = etg & ~32'd3;
        end else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end else if (res && tk) begin
        m_valid[i] = 1; m_tag[i] = m_tagof(epc); m_cnt[i] = 2; m_tgt[i] = etg & ~32'd3;
      end
      if (res && m_bc < MAXC) m_bc++;
      if (mis && m_mc < MAXC) m_mc++;
      m_rv = mis;
      if (mis) begin
        m_rpc = tk ? etg : epc + 32'd4;
        rd_q.push_back(m_rpc);
      end
    end
    o.rv = m_rv; o.rpc = m_rpc; o.bc = m_bc; o.mc = m_mc;
    out_q.push_back(o);
  endtask

  task automatic idle(input logic [31:0] ipc);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, ipc, 1'b1);
  endtask

  task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, pc, tk, tg, pc, 1'b1);
  endtask

  function automatic logic [31:0] rnd_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return 32'h1000 + 32'($urandom_range(0, 1)) * 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
  endfunction

  function automatic logic [31:0] rnd_tgt();
    case ($urandom_range(0, 3))
      0:       return 32'h40;
      1:       return 32'h80;
      2:       return 32'hFFFF_FFFC;
      default: return $urandom & ~32'd3;
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin
    pred_t p;
    out_t  o;
    forever begin
      @(negedge clock);
      #2;
      if (pred_q.size() > 0) begin
        p = pred_q.pop_front();
        if (p.chk) begin
          chk($sformatf("pred_taken@%h", p.pc), 32'(pred_taken), 32'(p.tk));
          chk($sformatf("pred_target@%h", p.pc), pred_target, p.tg);
        end
      end
      // Registered outputs reflect the previous cycle's entry.
      if (out_q.size() >= 2) begin
        o = out_q.pop_front();
        chk("redirect_valid", 32'(redirect_valid), 32'(o.rv));
        chk("redirect_pc", redirect_pc, o.rpc);
        chk("branch_count", 32'(branch_count), 32'(o.bc));
        chk("mispredict_count", 32'(mispredict_count), 32'(o.mc));
      end
      if (redirect_valid === 1'b1) begin
        if (rd_q.size() == 0) chk("unexpected_redirect", 32'(redirect_valid), 32'd0);
        else chk("redirect_target", redirect_pc, rd_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; if_pc = '0; ex_valid = 0; ex_branch = 0; ex_stall = 0;
    ex_pc = '0; ex_pred_taken = 0; ex_pred_target = '0; ex_taken = 0; ex_target = '0;

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100, 1'b1);
    idle(32'h100);                         // cold miss
    br(32'h100, 1'b1, 32'h80);             // mispredict -> redirect 0x80
    br(32'h100, 1'b1, 32'h80);             // shadow of redirect: ignored
    repeat (3) br(32'h100, 1'b1, 32'h80);  // train to ST
    idle(32'h100);
    br(32'h100, 1'b0, 32'h80);             // hysteresis: redirect 0x104
    idle(32'h100);                         // still predicts taken
    br(32'h100, 1'b0, 32'h80);
    idle(32'h100);                         // now not taken
    br(32'h200, 1'b1, 32'h200);            // alias replaces tag
    idle(32'h100);
    idle(32'h200);
    br(32'h200, 1'b1, 32'h300);            // target change
    idle(32'h200);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h340, 1'b1, 32'h40, 32'h340, 1'b1);
    br(32'h340, 1'b1, 32'h40);             // resolves once after stall
    idle(32'h340);
    br(32'h200, 1'b1, 32'h300);
    // reset in the cycle whose edge would raise the redirect
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 32'h300, 32'h200, 1'b1);
    idle(32'h200);
    idle(32'hFFFF_FFFC);                   // +4 wraps to 0
    br(32'hFFFF_FFFC, 1'b1, 32'h10);
    idle(32'hFFFF_FFFC);
    br(32'hFFFF_FFFC, 1'b1, 32'h10);
    br(32'hFFFF_FFFC, 1'b0, 32'h10);       // redirect to 0
    idle(32'hFFFF_FFFC);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] epc;
      epc = rnd_pc();
      cyc(($urandom_range(0, 499) != 0),
          ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 2),
          epc, 1'($urandom_range(0, 1)), rnd_tgt(),
          ($urandom_range(0, 1) != 0) ? epc : rnd_pc(),
          ($urandom_range(0, 19) < 17));
    end

    repeat (3) idle(32'h0);
    @(negedge clock);
    #3;
    chk("redirect_drain", 32'(rd_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and redirect unit for the pipelined RISC-V core. At IF it indexes a direct-mapped table of 2-bit saturating counters with branch target buffer (BTB) entries and supplies a predicted next PC. At EX it consumes the branch outcome (`branch_taken`) and the computed target, updates the table, and issues a registered redirect on a misprediction so the pipeline can flush the wrong path.

## Interface
Parameters:
- INDEX_BITS, 6, table index width; ENTRIES = 2^INDEX_BITS
- TAG_BITS, 30-INDEX_BITS, tag width taken from pc[31:2+INDEX_BITS]
- CNT_WIDTH, 32, width of the statistics counters

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  synchronous, active-low
- if_pc  in  32  PC of the instruction being fetched
- pred_taken  out  1  prediction for if_pc (combinational from table state)
- pred_target  out  32  predicted next PC: BTB target if pred_taken, else if_pc+4
- ex_valid  in  1  EX holds a real, non-flushed instruction
- ex_branch  in  1  EX instruction is a conditional branch (Branch control bit)
- ex_stall  in  1  EX frozen this cycle; no update, no redirect
- ex_pc  in  32  PC of the EX instruction
- ex_pred_taken  in  1  pred_taken carried down the pipeline with that instruction
- ex_pred_target  in  32  pred_target carried down the pipeline with that instruction
- ex_taken  in  1  resolved outcome (branch_taken)
- ex_target  in  32  resolved branch target
- redirect_valid  out  1  registered; flush IF/ID/EX and fetch from redirect_pc
- redirect_pc  out  32  registered; correct next PC
- branch_count  out  CNT_WIDTH  resolved branches, saturating
- mispredict_count  out  CNT_WIDTH  mispredictions, saturating

## Operation
- Entry fields: valid, tag, cnt[1:0], target[31:2]. Index = pc[2+INDEX_BITS-1:2].
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11. A counter predicts taken iff cnt[1]=1.
- Lookup: hit = valid && tag match. pred_taken = hit && cnt[1]. pred_target = pred_taken ? {target,2'b00} : if_pc+4. All arithmetic is mod 2^32; 0xFFFFFFFC+4 wraps to 0.
- A resolve occurs when ex_valid && ex_branch && !ex_stall && !redirect_valid.
- Update on a resolve:
  - Hit and taken: cnt saturating-increments (ST stays ST). Target is rewritten.
  - Hit and not taken: cnt saturating-decrements (SNT stays SNT).
  - Miss and taken: allocate or overwrite the entry with valid=1, the new tag, cnt=WT, and target.
  - Miss and not taken: no change.
- Mispredict = resolve && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target)).
- Mispredict effects:
  - Next cycle: redirect_valid=1 and redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - Otherwise redirect_valid=0, and redirect_pc holds its last value.
- While redirect_valid=1, EX inputs are ignored: that instruction is wrong-path, so there is no update and no count.
- Every resolve increments branch_count. Every mispredict increments mispredict_count. Both saturate at all-ones.
- A non-branch with ex_pred_taken=1 (stale alias) is neither corrected nor counted; the table only learns from branches.

## Timing
- Prediction: zero latency, combinational from if_pc.
- Table write: at the rising edge ending the resolve cycle.
- Redirect: exactly 1 cycle after the resolve cycle. It is a 1-cycle pulse per mispredict. Back-to-back redirects are impossible, because of the ignore rule.
- Same-cycle read/write of one index: the read returns the pre-update (old) entry; there is no bypass.
- ex_stall held for N cycles: the branch resolves once, on the first unstalled cycle.
- Reset asserted (reset=0 at an edge):
  - All entries become valid=0, cnt=WNT, tag=0, target=0.
  - redirect_valid=0, redirect_pc=0, both counters=0.
  - Any pending redirect is dropped, including when reset lands mid-operation.
  - pred_taken=0 from the first cycle after reset.

## Structure
- constants.v gains `BHT_SNT`, `BHT_WNT`, `BHT_WT`, `BHT_ST`.
- config.vh gains `BHT_INDEX_BITS`, which defaults the parameter.
- Sub-module `sat_counter2`: combinational next-state (cnt, taken) -> cnt'. It is used for the update and unit-tested alone.
- The table is plain register arrays (valid/tag/cnt/target) with reset loops, not an inferred RAM, because reset must clear every entry synchronously.

## Test plan
- Cold miss:
  - After reset, if_pc=0x100 -> pred_taken=0, pred_target=0x104.
  - Branch at 0x100 resolves taken to 0x80 -> next cycle redirect_valid=1, redirect_pc=0x80, mispredict_count=1.
- Training: repeat that branch taken 3 more times with correct predictions -> cnt reaches ST, no further redirects, branch_count=4, mispredict_count=1.
- Hysteresis:
  - From ST, one not-taken -> mispredict, redirect_pc=0x104, cnt=WT, and it still predicts taken.
  - A second not-taken -> cnt=WNT, pred_taken=0.
- Alias/target change:
  - 0x100 and 0x100+ENTRIES*4 share an index; the second, taken to 0x200, replaces the tag, and 0x100 then misses.
  - Same PC with a new target while predicted taken -> redirect to the new target.
- Stall and shadow:
  - ex_stall=1 for 3 cycles on a mispredicting branch -> single update, single redirect.
  - A branch in EX during the redirect cycle -> no update, no count change.
- Reset mid-flight: reset=0 in the cycle redirect_valid would rise -> redirect_valid stays 0, counters=0, and the trained PC predicts not-taken.
